binary_to_bcd_seq: RTL and testbench
====================================

# binary_to_bcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It supersedes the fixed 8-bit, 3-digit converter. It adds:
- configurable operand width and digit count;
- a start/busy/done handshake;
- overflow detection;
- optional signed input.

It sits between arithmetic/counter logic and the seven-segment display drivers.

## Interface
- `WIDTH`, 8: binary operand width in bits (≥ 2).
- `DIGITS`, 3: number of BCD output digits (≥ 1).
- `clk` input 1: clock; all state changes on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request conversion of `binary_value`; sampled only when accepting (IDLE or DONE state).
- `binary_value` input WIDTH: operand, captured on the accepting edge; may change afterwards.
- `busy` output 1: high while a conversion is in progress (SHIFT state).
- `done` output 1: one-cycle pulse, result valid.
- `bcd` output 4*DIGITS: result; digit i occupies bits [4i+3:4i], digit 0 = ones.
- `overflow` output 1: result did not fit in DIGITS digits; valid with `done`, held with `bcd`.
- `negative` output 1: operand was negative (signed build only); held with `bcd`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `start` = 1: capture operand into shift register, clear digit register and bit counter, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**, once per cycle:
  - In every digit ≥ 5, add 3.
  - Shift {digits, operand} left by one; the operand MSB enters digit 0 LSB.
  - If the bit shifted out of the top digit is 1, set the sticky overflow flag.
  - Increment the counter.
  - After the WIDTH-th shift, write digits to `bcd`, the flag to `overflow`, and the sign to `negative`, then go to DONE.
- **DONE**: `done` = 1 for this cycle.
  - `start` = 1: accept a new operand (back-to-back, go to SHIFT).
  - Otherwise go to IDLE.
- `start` in SHIFT is ignored; it is neither queued nor aborting.
- **Overflow** (value ≥ 10^DIGITS): `bcd` = value mod 10^DIGITS and `overflow` = 1. Otherwise `overflow` = 0.
- `bcd`, `overflow` and `negative` change only on conversion completion or reset; they hold between conversions.
- Counter width is clog2(WIDTH+1). Digit adders are 4-bit; add-3 never exceeds 4 bits.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, `busy` = 0, `done` = 0, `bcd` = 0, `overflow` = 0, `negative` = 0, counter = 0.
- Reset mid-conversion aborts it; no `done` is produced. Reset has priority over `start`.
- Accepting edge E0 (`start` = 1): `busy` = 1 from E0 until E_WIDTH.
- Shifts occur on edges E1..E_WIDTH.
- After E_WIDTH:
  - `busy` = 0 and `done` = 1 for exactly one cycle;
  - `bcd` is valid from the same cycle.
- Latency: `done` asserts WIDTH cycles after the accepting edge.
- Throughput: one conversion per WIDTH+1 cycles with `start` held high.
- `busy` and `done` are never both high.

## Configuration
- Macro: `BINARY_TO_BCD_SIGNED_EN`.
- **Defined**:
  - `binary_value` is two's complement.
  - The magnitude is captured (−2^(WIDTH−1) converts to 2^(WIDTH−1)).
  - `negative` = operand sign, registered at completion.
- **Undefined**:
  - `binary_value` is unsigned.
  - `negative` is tied to 0.
  - No negation logic is present.

## Test plan
- **Full range, unsigned, WIDTH=8, DIGITS=3**:
  - Sweep 0..255.
  - Each `done` gives the correct BCD: 0 → 0x000, 9 → 0x009, 10 → 0x010, 255 → 0x255.
  - `overflow` = 0 throughout.
  - `done` asserts exactly 8 cycles after the accepting edge.
- **Overflow, WIDTH=8, DIGITS=2**:
  - 99 → `bcd` 0x99, `overflow` 0.
  - 100 → 0x00, `overflow` 1.
  - 200 → 0x00, `overflow` 1.
  - 255 → 0x55, `overflow` 1.
- **Handshake**:
  - Pulse `start` with 123, then pulse `start` with 45 at cycle 3 while `busy`.
  - The second request is ignored; the single `done` carries 0x123.
  - `bcd` holds 0x123 while idle.
- **Back-to-back**:
  - Hold `start` = 1, operand 17 then 250 presented at the DONE cycle.
  - `done` pulses 9 cycles apart with 0x017 then 0x250.
- **Reset mid-conversion**:
  - Start 200; drop `rst_n` at cycle 4.
  - No `done`; all outputs 0.
  - A subsequent conversion of 7 yields 0x007.
- **Signed build, WIDTH=8, DIGITS=3**:
  - −128 → 0x128, `negative` 1.
  - −1 → 0x001, `negative` 1.
  - 127 → 0x127, `negative` 0.

Source files
------------

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one operand bit per clock).
// Define BINARY_TO_BCD_SIGNED_EN to treat binary_value as two's complement and report its sign.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary_value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  negative
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] operand;
  logic [BW-1:0]    digits;
  logic [CW-1:0]    cnt;
  logic             ovf_sticky;

  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    digits_next;
  logic             ovf_next;
  logic [WIDTH-1:0] magnitude;

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  // A corrected top digit of 8 or more means the true value no longer fits in DIGITS digits.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      else
        adjusted[4*i +: 4] = digits[4*i +: 4];
    end
    digits_next = {adjusted[BW-2:0], operand[WIDTH-1]};
    ovf_next    = ovf_sticky | adjusted[BW-1];
  end

`ifdef BINARY_TO_BCD_SIGNED_EN
  logic sign_cap;

  // The most negative operand negates to itself, which read unsigned is exactly its magnitude.
  assign magnitude = binary_value[WIDTH-1] ? ((~binary_value) + WIDTH'(1)) : binary_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_cap <= 1'b0;
      negative <= 1'b0;
    end else if (start && (state == S_IDLE || state == S_DONE)) begin
      sign_cap <= binary_value[WIDTH-1];
    end else if (state == S_SHIFT && cnt == LAST_CNT) begin
      negative <= sign_cap;
    end
  end
`else
  assign magnitude = binary_value;
  assign negative  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      operand    <= '0;
      digits     <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            operand    <= magnitude;
            digits     <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            state      <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          operand    <= {operand[WIDTH-2:0], 1'b0};
          digits     <= digits_next;
          ovf_sticky <= ovf_next;
          cnt        <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            bcd      <= digits_next;
            overflow <= ovf_next;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: a 3-digit and a 2-digit instance share the same stimulus,
// and a scoreboard checks every done pulse against a decimal-arithmetic model.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  binary_value;
  logic        busy, done, overflow, negative;
  logic [11:0] bcd;
  logic        busy2, done2, overflow2, negative2;
  logic [7:0]  bcd2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] b3;
    logic        o3;
    logic [7:0]  b2;
    logic        o2;
    logic        neg;
    int          acc;
  } exp_t;

  exp_t sb[$];

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary_value(binary_value),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .negative(negative)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .binary_value(binary_value),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2), .negative(negative2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int val);
    logic [11:0] r = '0;
    int v = val;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic push_expect(input logic [7:0] v, input int acc);
    exp_t e;
    int mag;
    logic neg;
    logic [11:0] full;
`ifdef BINARY_TO_BCD_SIGNED_EN
    neg = v[7];
    mag = v[7] ? 256 - int'(v) : int'(v);
`else
    neg = 1'b0;
    mag = int'(v);
`endif
    full  = to_bcd(mag);
    e.b3  = full;
    e.o3  = (mag >= 1000);
    e.b2  = full[7:0];
    e.o2  = (mag >= 100);
    e.neg = neg;
    e.acc = acc;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (busy && done) check("busy_done_exclusive", 1, 0);
    if (done || done2) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_d3", 32'(done), 1);
        check("done_d2", 32'(done2), 1);
        check("latency", 32'(cyc - e.acc), 8);
        check("bcd_d3", 32'(bcd), 32'(e.b3));
        check("ovf_d3", 32'(overflow), 32'(e.o3));
        check("bcd_d2", 32'(bcd2), 32'(e.b2));
        check("ovf_d2", 32'(overflow2), 32'(e.o2));
        check("negative", 32'(negative), 32'(e.neg));
      end
    end
  end

  task automatic issue(input logic [7:0] v);
    @(negedge clk);
    start = 1'b1;
    binary_value = v;
    push_expect(v, cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < 40), 1);
  endtask

  task automatic b2b(input logic [7:0] v1, input logic [7:0] v2);
    @(negedge clk);
    start = 1'b1;
    binary_value = v1;
    push_expect(v1, cyc + 1);
    repeat (9) @(negedge clk);
    binary_value = v2;
    push_expect(v2, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_bcd"}, 32'(bcd), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_neg"}, 32'(negative), 0);
    check({tag, "_bcd2"}, 32'(bcd2), 0);
    check({tag, "_ovf2"}, 32'(overflow2), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    binary_value = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 256; v++) begin
      issue(8'(v));
      wait_done();
    end

    // Second request arrives while busy and must be dropped.
    @(negedge clk);
    start = 1'b1;
    binary_value = 8'd123;
    push_expect(8'd123, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    binary_value = 8'd45;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("hold_bcd", 32'(bcd), 32'h123);
    check("hold_busy", 32'(busy), 0);

    b2b(8'd17, 8'd250);

    issue(8'd200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_idle_zero("midreset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd7);
    wait_done();

    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(8'($urandom_range(0, 255)));
      wait_done();
    end

    for (int k = 0; k < 20; k++) begin
      b2b(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (12) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
